// File: rtl/tb_wishbone_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS bench drivers share one DUT port,
// with CYC-based bus locking and an ack timeout that turns a hung cycle into ERR.
module tb_wishbone_arbiter #(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned ADDR_WIDTH     = 30,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned GW            = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    localparam int unsigned SW            = DATA_WIDTH / 8
) (
    input  logic                              clk12,
    input  logic                              reset,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_datwr,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_datrd,
    input  logic [NUM_MASTERS*SW-1:0]         m_sel,
    input  logic [NUM_MASTERS-1:0]            m_cyc,
    input  logic [NUM_MASTERS-1:0]            m_stb,
    input  logic [NUM_MASTERS-1:0]            m_we,
    input  logic [NUM_MASTERS*3-1:0]          m_cti,
    input  logic [NUM_MASTERS*2-1:0]          m_bte,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic [NUM_MASTERS-1:0]            m_err,
    output logic [ADDR_WIDTH-1:0]             wishbone_adr,
    output logic [DATA_WIDTH-1:0]             wishbone_datwr,
    output logic [SW-1:0]                     wishbone_sel,
    output logic                              wishbone_cyc,
    output logic                              wishbone_stb,
    output logic                              wishbone_we,
    output logic [2:0]                        wishbone_cti,
    output logic [1:0]                        wishbone_bte,
    input  logic [DATA_WIDTH-1:0]             wishbone_datrd,
    input  logic                              wishbone_ack,
    input  logic                              wishbone_err,
    output logic [GW-1:0]                     grant,
    output logic                              busy,
    output logic [15:0]                       timeout_count
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        TIMEOUT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_grant_q, last_grant_d;
    logic          busy_q, busy_d;
    logic [15:0]   timeout_count_q, timeout_count_d;
    logic [TW-1:0] timer_q, timer_d;

    logic          own_cyc;
    logic          own_stb;
    logic          dut_resp;
    logic          timeout_hit;
    logic          req_found;
    logic [GW-1:0] req_idx;
    logic [GW-1:0] rr_cand;
    logic [31:0]   rr_idx;
    int unsigned   gi;

    assign gi          = 32'(grant_q);
    assign own_cyc     = m_cyc[grant_q];
    assign own_stb     = m_stb[grant_q];
    assign dut_resp    = wishbone_ack | wishbone_err;
    // A DUT response in the final cycle wins over the forced error.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == GRANT) && own_cyc && own_stb
                         && !dut_resp && (timer_q == TW'(TIMEOUT_CYCLES - 1));

    assign grant         = grant_q;
    assign busy          = busy_q;
    assign timeout_count = timeout_count_q;

    // Round-robin search starting one past the previous owner.
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        rr_idx    = '0;
        rr_cand   = '0;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            rr_idx = 32'(last_grant_q) + k;
            if (rr_idx >= NUM_MASTERS) begin
                rr_idx = rr_idx - NUM_MASTERS;
            end
            rr_cand = GW'(rr_idx);
            if (!req_found && m_cyc[rr_cand]) begin
                req_found = 1'b1;
                req_idx   = rr_cand;
            end
        end
    end

    // Next-state, grant bookkeeping, timer and timeout counter.
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        last_grant_d    = last_grant_q;
        timeout_count_d = timeout_count_q;
        timer_d         = '0;
        unique case (state_q)
            IDLE: begin
                if (req_found) begin
                    state_d = GRANT;
                    grant_d = req_idx;
                end
            end
            GRANT: begin
                if (!own_cyc) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end else if (timeout_hit) begin
                    state_d = TIMEOUT;
                    if (timeout_count_q != 16'hFFFF) begin
                        timeout_count_d = timeout_count_q + 16'd1;
                    end
                end else if (own_stb && !dut_resp) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            TIMEOUT: begin
                if (!own_cyc) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk12) begin
        if (reset) begin
            state_q         <= IDLE;
            grant_q         <= '0;
            last_grant_q    <= GW'(NUM_MASTERS - 1);
            busy_q          <= 1'b0;
            timeout_count_q <= '0;
            timer_q         <= '0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            last_grant_q    <= last_grant_d;
            busy_q          <= busy_d;
            timeout_count_q <= timeout_count_d;
            timer_q         <= timer_d;
        end
    end

    // Owner's signals to the DUT; DUT responses back to the owner only.
    always_comb begin
        wishbone_adr   = '0;
        wishbone_datwr = '0;
        wishbone_sel   = '0;
        wishbone_cyc   = 1'b0;
        wishbone_stb   = 1'b0;
        wishbone_we    = 1'b0;
        wishbone_cti   = '0;
        wishbone_bte   = '0;
        m_ack          = '0;
        m_err          = '0;
        m_datrd        = '0;
        if (state_q == GRANT) begin
            wishbone_adr   = m_adr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            wishbone_datwr = m_datwr[gi*DATA_WIDTH +: DATA_WIDTH];
            wishbone_sel   = m_sel[gi*SW +: SW];
            wishbone_cyc   = own_cyc;
            wishbone_stb   = own_stb;
            wishbone_we    = m_we[grant_q];
            wishbone_cti   = m_cti[gi*3 +: 3];
            wishbone_bte   = m_bte[gi*2 +: 2];
            m_ack[grant_q] = wishbone_ack;
            m_err[grant_q] = wishbone_err | timeout_hit;
            m_datrd[gi*DATA_WIDTH +: DATA_WIDTH] = wishbone_datrd;
        end
    end

endmodule

// File: tb/tb_tb_wishbone_arbiter.sv
// Directed bench for tb_wishbone_arbiter: two masters, 16-cycle timeout.
module tb_tb_wishbone_arbiter;

    localparam int unsigned NM = 2;
    localparam int unsigned AW = 30;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic                clk12 = 1'b0;
    logic                reset;
    logic [NM*AW-1:0]    m_adr;
    logic [NM*DW-1:0]    m_datwr;
    logic [NM*DW-1:0]    m_datrd;
    logic [NM*SW-1:0]    m_sel;
    logic [NM-1:0]       m_cyc, m_stb, m_we;
    logic [NM*3-1:0]     m_cti;
    logic [NM*2-1:0]     m_bte;
    logic [NM-1:0]       m_ack, m_err;
    logic [AW-1:0]       wishbone_adr;
    logic [DW-1:0]       wishbone_datwr;
    logic [SW-1:0]       wishbone_sel;
    logic                wishbone_cyc, wishbone_stb, wishbone_we;
    logic [2:0]          wishbone_cti;
    logic [1:0]          wishbone_bte;
    logic [DW-1:0]       wishbone_datrd;
    logic                wishbone_ack, wishbone_err;
    logic [0:0]          grant;
    logic                busy;
    logic [15:0]         timeout_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk12 = ~clk12;

    tb_wishbone_arbiter #(
        .NUM_MASTERS   (NM),
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk12         (clk12),
        .reset         (reset),
        .m_adr         (m_adr),
        .m_datwr       (m_datwr),
        .m_datrd       (m_datrd),
        .m_sel         (m_sel),
        .m_cyc         (m_cyc),
        .m_stb         (m_stb),
        .m_we          (m_we),
        .m_cti         (m_cti),
        .m_bte         (m_bte),
        .m_ack         (m_ack),
        .m_err         (m_err),
        .wishbone_adr  (wishbone_adr),
        .wishbone_datwr(wishbone_datwr),
        .wishbone_sel  (wishbone_sel),
        .wishbone_cyc  (wishbone_cyc),
        .wishbone_stb  (wishbone_stb),
        .wishbone_we   (wishbone_we),
        .wishbone_cti  (wishbone_cti),
        .wishbone_bte  (wishbone_bte),
        .wishbone_datrd(wishbone_datrd),
        .wishbone_ack  (wishbone_ack),
        .wishbone_err  (wishbone_err),
        .grant         (grant),
        .busy          (busy),
        .timeout_count (timeout_count)
    );

    // Count one comparison and report it if it differs.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk12);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int own;
        reset          = 1'b1;
        m_adr          = '0;
        m_datwr        = '0;
        m_sel          = '0;
        m_cyc          = '0;
        m_stb          = '0;
        m_we           = '0;
        m_cti          = '0;
        m_bte          = '0;
        wishbone_datrd = '0;
        wishbone_ack   = 1'b0;
        wishbone_err   = 1'b0;
        reset_dut();

        // Reset state
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_tocnt", 64'(timeout_count), 64'd0);
        check("rst_cyc", 64'(wishbone_cyc), 64'd0);
        check("rst_ack", 64'(m_ack), 64'd0);
        check("rst_datrd", m_datrd, 64'd0);

        // 1: master 0 single read, DUT acks on the third granted cycle
        m_adr[0 +: AW] = 30'h100;
        m_sel[0 +: SW] = 4'hF;
        m_cyc = 2'b01;
        m_stb = 2'b01;
        #1;
        check("t1_cyc_latency", 64'(wishbone_cyc), 64'd0);
        tick();
        check("t1_cyc_up", 64'(wishbone_cyc), 64'd1);
        check("t1_adr", 64'(wishbone_adr), 64'h100);
        check("t1_grant", 64'(grant), 64'd0);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_wait1", 64'(m_ack), 64'd0);
        tick();
        check("t1_wait2", 64'(m_ack), 64'd0);
        tick();
        wishbone_ack   = 1'b1;
        wishbone_datrd = 32'hDEADBEEF;
        #1;
        check("t1_ack", 64'(m_ack), 64'b01);
        check("t1_datrd0", 64'(m_datrd[31:0]), 64'hDEADBEEF);
        check("t1_datrd1", 64'(m_datrd[63:32]), 64'd0);
        tick();
        wishbone_ack   = 1'b0;
        wishbone_datrd = '0;
        m_cyc = '0;
        m_stb = '0;
        #1;
        check("t1_ack_once", 64'(m_ack), 64'd0);
        tick();
        check("t1_idle", 64'(busy), 64'd0);

        // 2: both masters write 4 beats per CYC, repeating; grants alternate
        reset_dut();
        m_adr[0 +: AW]   = 30'h200;
        m_adr[AW +: AW]  = 30'h300;
        m_datwr[0 +: DW] = 32'hA0A0_0000;
        m_datwr[DW +: DW] = 32'hB1B1_1111;
        m_sel = 8'h3C;
        m_cyc = 2'b11;
        m_stb = 2'b11;
        m_we  = 2'b11;
        for (int r = 0; r < 4; r++) begin
            own = r % 2;
            tick();
            check("t2_grant", 64'(grant), 64'(own));
            check("t2_datwr", 64'(wishbone_datwr), (own == 0) ? 64'hA0A0_0000 : 64'hB1B1_1111);
            check("t2_sel", 64'(wishbone_sel), (own == 0) ? 64'hC : 64'h3);
            wishbone_ack = 1'b1;
            for (int b = 0; b < 4; b++) begin
                #1;
                check("t2_adr", 64'(wishbone_adr), (own == 0) ? 64'h200 : 64'h300);
                check("t2_ack", 64'(m_ack), (own == 0) ? 64'b01 : 64'b10);
                tick();
            end
            wishbone_ack = 1'b0;
            m_cyc[own] = 1'b0;
            m_stb[own] = 1'b0;
            #1;
            check("t2_hold", 64'(busy), 64'd1);
            tick();
            m_cyc[own] = 1'b1;
            m_stb[own] = 1'b1;
            #1;
            check("t2_gap_busy", 64'(busy), 64'd0);
            check("t2_gap_cyc", 64'(wishbone_cyc), 64'd0);
        end
        m_cyc = '0;
        m_stb = '0;
        m_we  = '0;

        // 3: master 1 4-beat incrementing burst, master 0 requests mid-burst
        m_adr[AW +: AW] = 30'h400;
        m_cti[3 +: 3]   = 3'b010;
        m_cyc = 2'b10;
        m_stb = 2'b10;
        tick();
        check("t3_grant", 64'(grant), 64'd1);
        check("t3_cti", 64'(wishbone_cti), 64'b010);
        for (int b = 0; b < 4; b++) begin
            m_adr[AW +: AW] = AW'(32'h400 + 32'(b));
            if (b == 3) m_cti[3 +: 3] = 3'b111;
            if (b == 1) begin
                m_cyc[0] = 1'b1;
                m_stb[0] = 1'b1;
            end
            wishbone_ack = 1'b1;
            #1;
            check("t3_lock", 64'(grant), 64'd1);
            check("t3_ack", 64'(m_ack), 64'b10);
            check("t3_adr", 64'(wishbone_adr), 64'h400 + 64'(b));
            tick();
        end
        #1;
        check("t3_cti_end", 64'(m_cti[5:3]), 64'b111);
        wishbone_ack = 1'b0;
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        m_cti    = '0;
        #1;
        check("t3_still1", 64'(grant), 64'd1);
        tick();
        check("t3_gap", 64'(busy), 64'd0);
        tick();
        check("t3_grant0", 64'(grant), 64'd0);
        check("t3_adr0", 64'(wishbone_adr), 64'h200);
        m_cyc = '0;
        m_stb = '0;
        tick();

        // 4: DUT never acks; forced error on the 16th strobe cycle
        m_cyc = 2'b01;
        m_stb = 2'b01;
        tick();
        for (int k = 1; k <= 15; k++) begin
            #1;
            check("t4_no_err", 64'(m_err), 64'd0);
            tick();
        end
        #1;
        check("t4_err", 64'(m_err), 64'b01);
        check("t4_cyc_last", 64'(wishbone_cyc), 64'd1);
        tick();
        check("t4_cyc_drop", 64'(wishbone_cyc), 64'd0);
        check("t4_err_once", 64'(m_err), 64'd0);
        check("t4_count", 64'(timeout_count), 64'd1);
        check("t4_busy", 64'(busy), 64'd1);
        wishbone_ack = 1'b1;
        #1;
        check("t4_ack_ignored", 64'(m_ack), 64'd0);
        wishbone_ack = 1'b0;
        tick();
        check("t4_busy_hold", 64'(busy), 64'd1);
        m_cyc = '0;
        m_stb = '0;
        tick();
        check("t4_idle", 64'(busy), 64'd0);

        // 5: DUT acks exactly on the timeout cycle
        m_cyc = 2'b01;
        m_stb = 2'b01;
        tick();
        for (int k = 1; k <= 15; k++) begin
            tick();
        end
        wishbone_ack = 1'b1;
        #1;
        check("t5_ack", 64'(m_ack), 64'b01);
        check("t5_no_err", 64'(m_err), 64'd0);
        tick();
        check("t5_cyc_kept", 64'(wishbone_cyc), 64'd1);
        check("t5_count", 64'(timeout_count), 64'd1);
        wishbone_ack = 1'b0;
        m_cyc = '0;
        m_stb = '0;
        tick();
        check("t5_idle", 64'(busy), 64'd0);

        // 6: reset during a granted transaction with a pending ack
        m_cyc = 2'b10;
        m_stb = 2'b10;
        tick();
        check("t6_grant1", 64'(grant), 64'd1);
        reset = 1'b1;
        tick();
        wishbone_ack   = 1'b1;
        wishbone_datrd = 32'h1234_5678;
        #1;
        check("t6_cyc", 64'(wishbone_cyc), 64'd0);
        check("t6_stb", 64'(wishbone_stb), 64'd0);
        check("t6_ack", 64'(m_ack), 64'd0);
        check("t6_datrd", m_datrd, 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_grant", 64'(grant), 64'd0);
        check("t6_count", 64'(timeout_count), 64'd0);
        reset          = 1'b0;
        wishbone_ack   = 1'b0;
        wishbone_datrd = '0;
        m_cyc = 2'b11;
        m_stb = 2'b11;
        tick();
        check("t6_first0", 64'(grant), 64'd0);
        check("t6_busy_up", 64'(busy), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tb_wishbone_arbiter.md
Name: tb_wishbone_arbiter

Overview:
Parametrised multi-master Wishbone arbiter for the USB test harness. It lets NUM_MASTERS independent bench drivers share the single DUT Wishbone port. Examples of drivers: a CSR poller, an endpoint FIFO loader, a test sequencer. Adds round-robin arbitration, bus locking for the duration of CYC, and a per-transaction ack timeout that converts a hung DUT cycle into a Wishbone ERR back to the requesting master. Sits between the cocotb driver ports and the dut wishbone_* pins, clocked in the DUT system domain.

Parameters:
NUM_MASTERS, 2, number of requesting masters (1..8)
ADDR_WIDTH, 30, word address width
DATA_WIDTH, 32, data width; SEL width is DATA_WIDTH/8
TIMEOUT_CYCLES, 1024, cycles of CYC&STB without ACK/ERR before forced ERR; 0 disables timeout
GW, $clog2(NUM_MASTERS) (min 1), grant index width (derived, not overridable)

Ports:
clk12  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
m_adr  in  NUM_MASTERS*ADDR_WIDTH  master addresses, master i at slice i
m_datwr  in  NUM_MASTERS*DATA_WIDTH  master write data
m_datrd  out  NUM_MASTERS*DATA_WIDTH  read data to masters
m_sel  in  NUM_MASTERS*DATA_WIDTH/8  byte selects
m_cyc / m_stb / m_we  in  NUM_MASTERS each  per-master cycle, strobe, write-enable
m_cti  in  NUM_MASTERS*3  cycle type
m_bte  in  NUM_MASTERS*2  burst type
m_ack / m_err  out  NUM_MASTERS each  per-master acknowledge and error
wishbone_adr, wishbone_datwr, wishbone_sel, wishbone_cyc, wishbone_stb, wishbone_we, wishbone_cti, wishbone_bte  out  ADDR_WIDTH, DATA_WIDTH, DATA_WIDTH/8, 1, 1, 1, 3, 2  to DUT
wishbone_datrd, wishbone_ack, wishbone_err  in  DATA_WIDTH, 1, 1  from DUT
grant  out  GW  index of current owner (valid while busy)
busy  out  1  high in GRANT or TIMEOUT state
timeout_count  out  16  saturating count of timeouts since reset

Behaviour:
- States: IDLE, GRANT, TIMEOUT.
- Reset values:
  - state=IDLE, grant=0, busy=0, timeout_count=0, timer=0.
  - last_grant=NUM_MASTERS-1, so master 0 wins first.
  - All slave-side outputs and all m_ack/m_err/m_datrd are 0.
- IDLE:
  - Round-robin search from last_grant+1 (mod NUM_MASTERS) for the first master with m_cyc high.
  - If found, register grant and go to GRANT. Arbitration latency is 1 cycle; the slave sees CYC the cycle after the request is sampled.
  - Slave cyc/stb are 0 in IDLE.
- GRANT:
  - Slave outputs are combinationally muxed from master[grant].
  - wishbone_ack/err/datrd are routed only to master[grant]; all other m_ack/m_err are 0 and their m_datrd is 0.
  - Grant is locked while m_cyc[grant] is high, covering multi-beat bursts (cti 010) and back-to-back STBs.
  - When m_cyc[grant] falls: go to IDLE and set last_grant=grant. There is a mandatory one idle cycle between owners; no same-cycle handover.
- Timer:
  - Cleared when state!=GRANT, when stb is low, or on ack/err.
  - Increments on each GRANT cycle with m_stb[grant]=1 and no ack/err.
  - When timer==TIMEOUT_CYCLES-1 and no ack/err that cycle:
    - m_err[grant] pulses for 1 cycle.
    - Slave cyc/stb forced 0 from the next cycle.
    - timeout_count increments, saturating at 0xFFFF.
    - Go to TIMEOUT.
  - Same-cycle DUT ack beats the timeout: ack is passed through, no err, no count.
- TIMEOUT: slave cyc/stb held 0, ACK/ERR from the DUT ignored. Return to IDLE (last_grant=grant) once m_cyc[grant] is low.
- wishbone_err from the DUT is passed through like ack and clears the timer.
- Reset mid-transaction: slave cyc/stb drop at the reset edge; no ack is delivered; state returns to IDLE.
- NUM_MASTERS=1: the arbiter degenerates to pass-through plus 1-cycle grant latency and timeout.

Test Plan:
1. Master 0 single read of adr 0x100; DUT acks after 3 cycles with 0xDEADBEEF -> wishbone_cyc rises 1 cycle after m_cyc[0]; m_ack[0]=1 for 1 cycle with m_datrd slice0=0xDEADBEEF; m_ack[1]=0 throughout.
2. Masters 0 and 1 request in the same cycle, each doing 4 single writes and repeating -> grants alternate 0,1,0,1 with exactly one idle cycle between owners; no interleaving inside a CYC.
3. Master 1 does a 4-beat incrementing burst (cti 010, 010, 010, 111) while master 0 requests mid-burst -> master 1 keeps the grant for all 4 acks; master 0 is granted only after m_cyc[1] falls.
4. TIMEOUT_CYCLES=16, DUT never acks -> m_err pulses on the 16th stb cycle; wishbone_cyc=0 the next cycle; timeout_count=1; busy stays high until the master drops cyc.
5. DUT acks exactly on the timeout cycle -> m_ack=1, m_err=0, timeout_count unchanged.
6. Assert reset during a granted transaction with a pending ack -> all outputs 0 on the next edge; after release, master 0 is granted first.
